dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width; only 32 is supported.
REQ-002 SHALL have parameter DEPTH, default 1024, memory size in XLEN-bit words (power of two).
REQ-003 SHALL have parameter WAIT, default 1, wait cycles between request accept and response (0..15).
REQ-004 SHALL have port clock  input  1  single clock, rising-edge.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid  input  1  request present.
REQ-007 SHALL have port req_ready  output  1  responder can accept a request.
REQ-008 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-009 SHALL have port req_funct3  input  3  RISC-V load/store funct3 (access size).
REQ-010 SHALL have port req_addr  input  XLEN  byte address.
REQ-011 SHALL have port req_wdata  input  XLEN  store data, right-justified in bits [7:0], [15:0] or [31:0].
REQ-012 SHALL have port rsp_valid  output  1  response present.
REQ-013 SHALL have port rsp_ready  input  1  requester accepts response.
REQ-014 SHALL have port rsp_rdata  output  XLEN  full aligned word read; sign/zero extension is the LSU's job.
REQ-015 SHALL have port rsp_err  output  1  access fault (see Configuration).

Function
REQ-016 SHALL serve one outstanding transaction at a time; FSM states IDLE, WAIT, RESP.
REQ-017 IDLE: req_ready=1; req_valid=1 transfers the request and latches all req_* fields; next state WAIT if WAIT>0, else RESP.
REQ-018 WAIT: req_ready=0; down-counter loads WAIT-1 on accept; at 0, next state RESP.
REQ-019 Memory access SHALL occur on the cycle entering RESP; a load presents word mem[addr[log2(DEPTH)+1:2]]; address bits above the index are ignored (wrap).
REQ-020 Stores SHALL write byte lanes only: SB lane addr[1:0] with wdata[7:0]; SH lanes 2*addr[1]..+1 with wdata[15:0]; SW all four lanes; unwritten lanes unchanged.
REQ-021 A store's rsp_rdata SHALL be 0.
REQ-022 RESP: rsp_valid=1; rsp_rdata/rsp_err held stable until rsp_ready=1; then next state IDLE.
REQ-023 Latency from accept to rsp_valid SHALL be WAIT+1 cycles; a back-to-back request is accepted no earlier than the cycle after the response handshake.
REQ-024 funct3 011 (LD/SD) SHALL be a fault at XLEN=32; funct3 11x SHALL be a fault.

Reset
REQ-025 reset_n low SHALL force IDLE, req_ready=1 after release, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0.
REQ-026 Reset during WAIT SHALL abandon the pending access; an uncommitted store SHALL not write memory.
REQ-027 Memory contents SHALL not be reset.

Configuration
REQ-028 Macro DMEM_MISALIGN_ERR_EN defined: half access with addr[0]=1, word access with addr[1:0]!=0, and REQ-024 cases SHALL give rsp_err=1, rsp_rdata=0, no memory write.
REQ-029 Macro undefined: rsp_err SHALL be tied 0; misaligned addresses are truncated to the natural alignment; funct3 011 is treated as a word access and 11x as a byte access.

Structure
REQ-030 Funct3 load/store encodings (LB..LWU, SB..SD) and FSM state encodings SHALL live in the shared defines header.
REQ-031 The byte-lane enable/data replication logic SHALL be a sub-module dmem_lane_gen (funct3, addr[1:0], wdata -> 4-bit byte enable, replicated write word, misaligned flag).

Verification
REQ-032 WAIT=1: SW 0xDEADBEEF @0x10, then LW @0x10 -> rsp_valid 2 cycles after each accept, rdata 0xDEADBEEF, err 0.
REQ-033 After REQ-032: SB 0x55 @0x11, LW @0x10 -> rdata 0xDEAD55EF; SH 0x1234 @0x12, LW -> 0x123455EF.
REQ-034 rsp_ready held 0 for 5 cycles -> rsp_valid, rdata stable throughout, req_ready=0 until handshake.
REQ-035 With DMEM_MISALIGN_ERR_EN: SW 0xFFFFFFFF @0x11 -> err 1, rdata 0; LW @0x10 still 0x123455EF.
REQ-036 Assert reset_n low during WAIT of SW 0x0 @0x10 -> rsp_valid 0; after release LW @0x10 returns the prior value.
REQ-037 WAIT=0 and DEPTH=1024: LW @0x1010 -> same data as @0x10, response 1 cycle after accept.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: funct3 access encodings,
// FSM state encoding and access-size helpers.
package dmem_responder_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_SD  = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_e;

    // 11x has no RV32 meaning and degrades to a byte access; 011 degrades to a word.
    function automatic size_e f3_size(input logic [2:0] f3);
        size_e sz;
        case (f3)
            F3_LB, F3_LBU, F3_LWU, 3'b111: sz = SZ_B;
            F3_LH, F3_LHU:                 sz = SZ_H;
            default:                       sz = SZ_W;
        endcase
        return sz;
    endfunction

    function automatic logic f3_fault(input logic [2:0] f3);
        return (f3 == F3_LD) || (f3 == F3_SD) || (f3[2:1] == 2'b11);
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between a load/store unit (master) and the data-memory
// responder (slave).
interface dmem_responder_if #(
    parameter int XLEN = 32
) ();

    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_rdata;
    logic            rsp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dmem_lane_gen.sv
// Byte-lane enable and write-data replication for a single load/store access,
// plus a flag for addresses not naturally aligned to the access size.
module dmem_lane_gen
    import dmem_responder_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wword_o,
    output logic        misalign_o
);

    always_comb begin
        be_o       = '0;
        wword_o    = wdata_i;
        misalign_o = 1'b0;
        case (f3_size(funct3_i))
            SZ_B: begin
                be_o    = 4'b0001 << addr_lo_i;
                wword_o = {4{wdata_i[7:0]}};
            end
            SZ_H: begin
                be_o       = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wword_o    = {2{wdata_i[15:0]}};
                misalign_o = addr_lo_i[0];
            end
            default: begin
                be_o       = '1;
                misalign_o = |addr_lo_i;
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with a fixed WAIT-cycle latency.
// Define DMEM_MISALIGN_ERR_EN to fault misaligned and illegal-size accesses.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 1024,
    parameter int WAIT  = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    dmem_responder_if.slave  bus
);

    localparam int         IDXW     = $clog2(DEPTH);
    localparam logic [3:0] CNT_LOAD = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            we_q, we_d;
    logic [2:0]      f3_q, f3_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            err_q, err_d;

    logic [XLEN-1:0] mem_q [DEPTH];

    logic            access;
    logic            mem_we;
    logic            fault;
    logic            acc_we;
    logic [2:0]      acc_f3;
    logic [XLEN-1:0] acc_addr;
    logic [XLEN-1:0] acc_wdata;
    logic [IDXW-1:0] acc_idx;
    logic [3:0]      be;
    logic [31:0]     wword;
    logic            misalign;

    // With WAIT=0 the access happens on the accept edge, before the fields are latched.
    assign acc_we    = (state_q == ST_IDLE) ? bus.req_we     : we_q;
    assign acc_f3    = (state_q == ST_IDLE) ? bus.req_funct3 : f3_q;
    assign acc_addr  = (state_q == ST_IDLE) ? bus.req_addr   : addr_q;
    assign acc_wdata = (state_q == ST_IDLE) ? bus.req_wdata  : wdata_q;
    assign acc_idx   = acc_addr[IDXW+1:2];

    dmem_lane_gen u_lane_gen (
        .funct3_i   (acc_f3),
        .addr_lo_i  (acc_addr[1:0]),
        .wdata_i    (acc_wdata),
        .be_o       (be),
        .wword_o    (wword),
        .misalign_o (misalign)
    );

`ifdef DMEM_MISALIGN_ERR_EN
    assign fault = misalign | f3_fault(acc_f3);
`else
    logic unused_misalign;
    assign unused_misalign = misalign;
    assign fault = 1'b0;
`endif

    logic unused_addr_hi;
    assign unused_addr_hi = ^acc_addr[XLEN-1:IDXW+2];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        access  = 1'b0;
        mem_we  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    f3_d    = bus.req_funct3;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    if (WAIT == 0) begin
                        state_d = ST_RESP;
                        access  = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                    access  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (access) begin
            err_d   = fault;
            mem_we  = acc_we & ~fault;
            rdata_d = (fault || acc_we) ? '0 : mem_q[acc_idx];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Storage is deliberately outside reset so contents survive a reset pulse.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (be[b]) mem_q[acc_idx][8*b +: 8] <= wword[8*b +: 8];
            end
        end
    end

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a WAIT=1 instance for the main sequence
// and a WAIT=0 instance for zero-wait latency and address wrap.
module tb_dmem_responder;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b0;
    logic        sel     = 1'b0;
    logic        t_valid = 1'b0;
    logic        t_we    = 1'b0;
    logic [2:0]  t_f3    = '0;
    logic [31:0] t_addr  = '0;
    logic [31:0] t_wdata = '0;
    logic        t_rready = 1'b0;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    dmem_responder_if #(.XLEN(32)) bus1 ();
    dmem_responder_if #(.XLEN(32)) bus0 ();

    assign bus1.req_valid  = t_valid & ~sel;
    assign bus0.req_valid  = t_valid & sel;
    assign bus1.rsp_ready  = t_rready & ~sel;
    assign bus0.rsp_ready  = t_rready & sel;
    assign bus1.req_we     = t_we;
    assign bus0.req_we     = t_we;
    assign bus1.req_funct3 = t_f3;
    assign bus0.req_funct3 = t_f3;
    assign bus1.req_addr   = t_addr;
    assign bus0.req_addr   = t_addr;
    assign bus1.req_wdata  = t_wdata;
    assign bus0.req_wdata  = t_wdata;

    logic        o_req_ready;
    logic        o_rsp_valid;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_err;
    assign o_req_ready = sel ? bus0.req_ready : bus1.req_ready;
    assign o_rsp_valid = sel ? bus0.rsp_valid : bus1.rsp_valid;
    assign o_rsp_rdata = sel ? bus0.rsp_rdata : bus1.rsp_rdata;
    assign o_rsp_err   = sel ? bus0.rsp_err   : bus1.rsp_err;

    dmem_responder #(.XLEN(32), .DEPTH(1024), .WAIT(1)) u_dut_w1 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus1)
    );

    dmem_responder #(.XLEN(32), .DEPTH(1024), .WAIT(0)) u_dut_w0 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One request/response; hold = cycles rsp_ready stays low once the response is up.
    task automatic txn(input string tag, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err,
                       input int exp_lat, input int hold);
        int lat;
        t_valid = 1'b1;
        t_we    = we;
        t_f3    = f3;
        t_addr  = addr;
        t_wdata = wdata;
        chk({tag, ".req_ready"}, 32'(o_req_ready), 32'd1);
        @(posedge clock); #1;
        t_valid = 1'b0;
        lat = 1;
        while (!o_rsp_valid && lat < 20) begin
            @(posedge clock); #1;
            lat++;
        end
        chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, ".rdata"}, o_rsp_rdata, exp_rdata);
        chk({tag, ".err"}, 32'(o_rsp_err), 32'(exp_err));
        for (int k = 0; k < hold; k++) begin
            @(posedge clock); #1;
            chk({tag, ".stall_valid"}, 32'(o_rsp_valid), 32'd1);
            chk({tag, ".stall_rdata"}, o_rsp_rdata, exp_rdata);
            chk({tag, ".stall_req_ready"}, 32'(o_req_ready), 32'd0);
        end
        t_rready = 1'b1;
        @(posedge clock); #1;
        t_rready = 1'b0;
        chk({tag, ".post_valid"}, 32'(o_rsp_valid), 32'd0);
        chk({tag, ".post_req_ready"}, 32'(o_req_ready), 32'd1);
    endtask

    initial begin
        #1;
        chk("reset.req_ready", 32'(o_req_ready), 32'd1);
        chk("reset.rsp_valid", 32'(o_rsp_valid), 32'd0);
        chk("reset.rdata", o_rsp_rdata, 32'd0);
        chk("reset.err", 32'(o_rsp_err), 32'd0);
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(posedge clock); #1;

        txn("sw_10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, 0);
        txn("lw_10", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, 0);
        txn("sb_11", 1'b1, 3'b000, 32'h11, 32'h00000055, 32'h0, 1'b0, 2, 0);
        txn("lw_sb", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD55EF, 1'b0, 2, 0);
        txn("sh_12", 1'b1, 3'b001, 32'h12, 32'h00001234, 32'h0, 1'b0, 2, 0);
        txn("lw_sh", 1'b0, 3'b010, 32'h10, 32'h0, 32'h123455EF, 1'b0, 2, 0);
        txn("lw_stall", 1'b0, 3'b010, 32'h10, 32'h0, 32'h123455EF, 1'b0, 2, 5);
        txn("lb_13", 1'b0, 3'b000, 32'h13, 32'h0, 32'h123455EF, 1'b0, 2, 0);

`ifdef DMEM_MISALIGN_ERR_EN
        txn("sw_mis", 1'b1, 3'b010, 32'h11, 32'hFFFFFFFF, 32'h0, 1'b1, 2, 0);
        txn("lw_after_mis", 1'b0, 3'b010, 32'h10, 32'h0, 32'h123455EF, 1'b0, 2, 0);
        txn("ld", 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 2, 0);
        txn("lwu", 1'b0, 3'b110, 32'h10, 32'h0, 32'h0, 1'b1, 2, 0);
        txn("lh_mis", 1'b0, 3'b001, 32'h11, 32'h0, 32'h0, 1'b1, 2, 0);
        txn("sh_mis", 1'b1, 3'b001, 32'h13, 32'h0000ABCD, 32'h0, 1'b1, 2, 0);
        txn("lw_after_sh_mis", 1'b0, 3'b010, 32'h10, 32'h0, 32'h123455EF, 1'b0, 2, 0);
`else
        txn("sw_mis", 1'b1, 3'b010, 32'h11, 32'hFFFFFFFF, 32'h0, 1'b0, 2, 0);
        txn("lw_after_mis", 1'b0, 3'b010, 32'h10, 32'h0, 32'hFFFFFFFF, 1'b0, 2, 0);
        txn("ld", 1'b0, 3'b011, 32'h10, 32'h0, 32'hFFFFFFFF, 1'b0, 2, 0);
        txn("sb_f3_110", 1'b1, 3'b110, 32'h13, 32'h00000012, 32'h0, 1'b0, 2, 0);
        txn("lw_after_110", 1'b0, 3'b010, 32'h10, 32'h0, 32'h12FFFFFF, 1'b0, 2, 0);
        txn("sh_mis", 1'b1, 3'b001, 32'h11, 32'h0000ABCD, 32'h0, 1'b0, 2, 0);
        txn("lw_after_sh_mis", 1'b0, 3'b010, 32'h10, 32'h0, 32'h12FFABCD, 1'b0, 2, 0);
        txn("sw_restore", 1'b1, 3'b010, 32'h10, 32'h123455EF, 32'h0, 1'b0, 2, 0);
`endif

        // Reset lands while the store is still counting down in WAIT.
        t_valid = 1'b1;
        t_we    = 1'b1;
        t_f3    = 3'b010;
        t_addr  = 32'h10;
        t_wdata = 32'h0;
        @(posedge clock); #1;
        t_valid = 1'b0;
        chk("rst_wait.in_wait", 32'(o_req_ready), 32'd0);
        reset_n = 1'b0;
        #1;
        chk("rst_wait.rsp_valid", 32'(o_rsp_valid), 32'd0);
        chk("rst_wait.req_ready", 32'(o_req_ready), 32'd1);
        chk("rst_wait.rdata", o_rsp_rdata, 32'd0);
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(posedge clock); #1;
        chk("rst_wait.after_valid", 32'(o_rsp_valid), 32'd0);
        txn("lw_after_rst", 1'b0, 3'b010, 32'h10, 32'h0, 32'h123455EF, 1'b0, 2, 0);

        sel = 1'b1;
        #1;
        txn("w0_sw_10", 1'b1, 3'b010, 32'h10, 32'hCAFEF00D, 32'h0, 1'b0, 1, 0);
        txn("w0_lw_1010", 1'b0, 3'b010, 32'h1010, 32'h0, 32'hCAFEF00D, 1'b0, 1, 0);
        txn("w0_lw_10_stall", 1'b0, 3'b010, 32'h10, 32'h0, 32'hCAFEF00D, 1'b0, 1, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
